demux_1_2_packer: RTL and testbench
===================================

Name: demux_1_2_packer

Overview:
Sequential 1:2 width packer. It is the write-side counterpart of the 2:1 lane-select mux. It accepts a stream of WIDTH-bit words and assembles each consecutive pair into one 2*WIDTH-bit word, with lane 0 in the low half and lane 1 in the high half, so the mux lane ordering (sel=0 → [WIDTH-1:0], sel=1 → [2*WIDTH-1:WIDTH]) round-trips. Both sides use valid/ready. The block sits between narrow producers (PE result lanes) and wide buffer/memory write ports.

Parameters:
- WIDTH, 8, width of one input lane word.
- OUT_WIDTH, 2*WIDTH, packed output width; must equal 2*WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept an input word this cycle.
- in_data  input  WIDTH  input lane word.
- in_last  input  1  marks the final word of a burst; forces emission of a partial word.
- out_valid  output  1  packed word available.
- out_ready  input  1  consumer accepts the packed word.
- out_data  output  OUT_WIDTH  packed word; lane 0 in [WIDTH-1:0], lane 1 in [2*WIDTH-1:WIDTH].
- out_mask  output  2  per-lane valid: 2'b11 for a full pair, 2'b01 for a partial flush.

Behaviour:
- Interface decision: one clock, `clk`; reset is `reset`, synchronous, active-high.
- Handshakes: input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
- State: `lane` (1 bit: 0 = expecting lane 0, 1 = expecting lane 1), stage register (WIDTH), output register (OUT_WIDTH + mask), out_valid flag.
- Reset (sync, takes priority over all other events): lane=0, stage=0, out_data=0, out_mask=0, out_valid=0, in_ready=1 from the cycle after reset deasserts.
- Reset mid-operation: a staged lane 0 and any unconsumed output word are dropped; no output is emitted.
- `out_free` = !out_valid | out_ready.
- Lane 0 accept when in_last=0: stage←in_data, lane←1. This is allowed even when out_valid=1 and out_ready=0, because the stage is independent of the output register.
- Lane 0 accept when in_last=1: it is a flush. Requires out_free. Output register←{WIDTH'b0, in_data}, mask←01, out_valid←1, lane stays 0.
- Lane 1 accept (in_last ignored): requires out_free. Output register←{in_data, stage}, mask←11, out_valid←1, lane←0.
- in_ready = (lane==0 & !in_last) | out_free.
  - in_ready depends combinationally on in_last, in_valid-independent data, and out_ready.
  - There is no combinational path from in_valid to in_ready.
- Latency: out_valid rises the cycle after the completing input handshake.
- Throughput: one input word per cycle sustained with out_ready=1; one output per 2 inputs.
- Output without a new completion: if out_ready=1 and no new completion occurs, out_valid←0.
- Simultaneous drain and load: output handshake plus a completion in the same cycle loads the new word with out_valid kept 1. There is no bubble and no loss.
- Output stability: out_data and out_mask hold stable while out_valid=1 and out_ready=0.
- Backpressure: with lane=1 and out_valid=1 & out_ready=0, in_ready=0. Nothing is overwritten.
- in_last on lane 1: treated as a normal pair completion, mask=11.
- No X propagation: out_data is fully defined after reset, and the high half is zero on a flush.

Test Plan:
- Reset, then inputs 0x11, 0x22 with out_ready=1 → one cycle after the 0x22 handshake, out_data=0x2211, out_mask=11, out_valid for exactly 1 cycle.
- Back-to-back stream 0x01..0x08 with in_valid=1, out_ready=1 → in_ready is constantly 1; outputs are 0x0201, 0x0403, 0x0605, 0x0807 on alternate cycles.
- Burst 0xA1, 0xA2, 0xA3 (last) → outputs 0xA2A1/mask 11, then 0x00A3/mask 01; lane returns to 0.
- out_ready=0 after the 0x2211 output, then send 0x33, 0x44:
  - 0x33 is accepted and in_ready drops for 0x44; out_data holds 0x2211.
  - Raising out_ready drains 0x2211 and accepts 0x44 in the same cycle.
  - Next cycle, out_data=0x4433.
- Send 0x55 (lane 0 staged), assert reset for 1 cycle, then 0x66, 0x77 → out_data=0x7766; 0x55 never appears.
- Lane 1 sent with in_last=1 (0x88, 0x99 last) → out_data=0x9988, out_mask=11.

Source files
------------

// File: rtl/demux_1_2_packer.sv
// Sequential 1:2 width packer: pairs consecutive WIDTH-bit words into one 2*WIDTH-bit word
// (lane 0 low, lane 1 high), with in_last forcing a half-filled flush.
module demux_1_2_packer #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 2 * WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [1:0]           out_mask
);

    logic             lane_p0;
    logic [WIDTH-1:0] stage_p0;
    logic             out_free;
    logic             in_fire;
    logic             complete;

    // A plain lane-0 word only touches the stage register, so it never waits on the output side.
    assign out_free = !out_valid || out_ready;
    assign in_ready = (!lane_p0 && !in_last) || out_free;
    assign in_fire  = in_valid && in_ready;
    assign complete = in_fire && (lane_p0 || in_last);

    // Stage boundary: stage register and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_p0   <= 1'b0;
            stage_p0  <= '0;
            out_data  <= '0;
            out_mask  <= 2'b00;
            out_valid <= 1'b0;
        end else begin
            if (in_fire && !lane_p0 && !in_last) begin
                stage_p0 <= in_data;
                lane_p0  <= 1'b1;
            end
            if (complete) begin
                lane_p0   <= 1'b0;
                out_valid <= 1'b1;
                if (lane_p0) begin
                    out_data <= {in_data, stage_p0};
                    out_mask <= 2'b11;
                end else begin
                    out_data <= {{WIDTH{1'b0}}, in_data};
                    out_mask <= 2'b01;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_demux_1_2_packer.sv
// Bench for demux_1_2_packer: directed vector table, then random traffic against a queue-based model.
module tb_demux_1_2_packer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [7:0]  in_data;
    logic [15:0] out_data;
    logic [1:0]  out_mask;

    always #5 clk = ~clk;

    demux_1_2_packer #(.WIDTH(8), .OUT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    typedef struct {
        logic        rst, iv, last, ordy;
        logic [7:0]  d;
        logic        chk, erdy, eov;
        logic [15:0] eod;
        logic [1:0]  em;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, iv, last, ordy, input logic [7:0] d,
                       input logic chk, erdy, eov, input logic [15:0] eod, input logic [1:0] em);
        vec_t v;
        v.rst = rst; v.iv = iv; v.last = last; v.ordy = ordy; v.d = d;
        v.chk = chk; v.erdy = erdy; v.eov = eov; v.eod = eod; v.em = em;
        tbl.push_back(v);
    endtask

    // Random-phase model: words waiting to be paired and packed words awaiting the consumer.
    logic [7:0]  pend_q[$];
    logic [17:0] outq[$];

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = 8'h00;

        // Each row: inputs applied this cycle; expectations are in_ready for these inputs and
        // the registered outputs left by previous cycles.
        //   rst iv la or data   chk rdy ov  out       mask
        add(1, 0, 0, 0, 8'h00, 0, 0, 0, 16'h0000, 2'b00);
        add(0, 0, 0, 1, 8'h00, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 1, 0, 1, 8'h11, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 1, 0, 1, 8'h22, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 16'h2211, 2'b11);
        add(0, 0, 0, 1, 8'h00, 1, 1, 0, 16'h2211, 2'b11);
        add(0, 1, 0, 1, 8'h01, 1, 1, 0, 16'h2211, 2'b11);
        add(0, 1, 0, 1, 8'h02, 1, 1, 0, 16'h2211, 2'b11);
        add(0, 1, 0, 1, 8'h03, 1, 1, 1, 16'h0201, 2'b11);
        add(0, 1, 0, 1, 8'h04, 1, 1, 0, 16'h0201, 2'b11);
        add(0, 1, 0, 1, 8'h05, 1, 1, 1, 16'h0403, 2'b11);
        add(0, 1, 0, 1, 8'h06, 1, 1, 0, 16'h0403, 2'b11);
        add(0, 1, 0, 1, 8'h07, 1, 1, 1, 16'h0605, 2'b11);
        add(0, 1, 0, 1, 8'h08, 1, 1, 0, 16'h0605, 2'b11);
        add(0, 1, 0, 1, 8'hA1, 1, 1, 1, 16'h0807, 2'b11);
        add(0, 1, 0, 1, 8'hA2, 1, 1, 0, 16'h0807, 2'b11);
        add(0, 1, 1, 1, 8'hA3, 1, 1, 1, 16'hA2A1, 2'b11);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 16'h00A3, 2'b01);
        add(0, 1, 0, 0, 8'h11, 1, 1, 0, 16'h00A3, 2'b01);
        add(0, 1, 0, 0, 8'h22, 1, 1, 0, 16'h00A3, 2'b01);
        add(0, 1, 0, 0, 8'h33, 1, 1, 1, 16'h2211, 2'b11);
        add(0, 1, 0, 0, 8'h44, 1, 0, 1, 16'h2211, 2'b11);
        add(0, 1, 0, 0, 8'h44, 1, 0, 1, 16'h2211, 2'b11);
        add(0, 1, 0, 1, 8'h44, 1, 1, 1, 16'h2211, 2'b11);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 16'h4433, 2'b11);
        add(0, 1, 0, 1, 8'h55, 1, 1, 0, 16'h4433, 2'b11);
        add(1, 0, 0, 1, 8'h00, 1, 1, 0, 16'h4433, 2'b11);
        add(0, 1, 0, 1, 8'h66, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 1, 0, 1, 8'h77, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 16'h7766, 2'b11);
        add(0, 1, 0, 1, 8'h88, 1, 1, 0, 16'h7766, 2'b11);
        add(0, 1, 1, 1, 8'h99, 1, 1, 0, 16'h7766, 2'b11);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 16'h9988, 2'b11);
        add(0, 0, 1, 0, 8'h00, 1, 0, 1, 16'h9988, 2'b11);
        add(1, 0, 0, 0, 8'h00, 1, 1, 1, 16'h9988, 2'b11);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 1, 1, 0, 8'hBB, 1, 1, 0, 16'h0000, 2'b00);
        add(0, 1, 1, 0, 8'hCC, 1, 0, 1, 16'h00BB, 2'b01);
        add(0, 1, 1, 1, 8'hCC, 1, 1, 1, 16'h00BB, 2'b01);
        add(0, 0, 0, 1, 8'h00, 1, 1, 1, 16'h00CC, 2'b01);
        add(0, 0, 0, 1, 8'h00, 1, 1, 0, 16'h00CC, 2'b01);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; in_valid = tbl[i].iv; in_last = tbl[i].last;
            out_ready = tbl[i].ordy; in_data = tbl[i].d;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].erdy});
                check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
                check($sformatf("vec%0d_out_data", i), {16'b0, out_data}, {16'b0, tbl[i].eod});
                check($sformatf("vec%0d_out_mask", i), {30'b0, out_mask}, {30'b0, tbl[i].em});
            end
        end

        // Random traffic against the model
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pend_q.delete();
        outq.delete();
        for (int c = 0; c < 400; c++) begin
            logic erdy, acc, drain;
            logic [17:0] w;
            if (c > 0) @(negedge clk);
            in_valid  = ($urandom_range(3) != 0);
            in_last   = ($urandom_range(3) == 0);
            out_ready = $urandom_range(1);
            in_data   = 8'($urandom);
            #1;
            erdy = (pend_q.size() == 0 && !in_last) || outq.size() == 0 || out_ready;
            check($sformatf("rnd%0d_in_ready", c), {31'b0, in_ready}, {31'b0, erdy});
            check($sformatf("rnd%0d_out_valid", c), {31'b0, out_valid}, {31'b0, outq.size() != 0});
            if (outq.size() != 0)
                check($sformatf("rnd%0d_out_word", c), {14'b0, out_mask, out_data}, {14'b0, outq[0]});
            acc   = in_valid && erdy;
            drain = (outq.size() != 0) && out_ready;
            if (drain) void'(outq.pop_front());
            if (acc) begin
                if (pend_q.size() != 0) begin
                    w = {2'b11, in_data, pend_q.pop_front()};
                    outq.push_back(w);
                end else if (in_last) begin
                    w = {2'b01, 8'h00, in_data};
                    outq.push_back(w);
                end else begin
                    pend_q.push_back(in_data);
                end
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
